// File: rtl/seg4_scan_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the 4-digit LED scan controller.
package seg4_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high g..a patterns; element 0 is the pattern for digit 0
  localparam logic [0:9][6:0] SEG_PAT = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_PAT[digit] : SEG_BLANK;
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift bit_in in at the bottom
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] r;
    r = bcd;
    for (int unsigned n = 0; n < 5; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return {r[18:0], bit_in};
  endfunction

endpackage

// File: rtl/seg4_scan_ctrl_if.sv
// Value/dots handshake between application logic and the scan controller.
interface seg4_scan_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        blank_lz;

  modport master (output in_valid, value, dots, blank_lz, input in_ready);
  modport slave  (input in_valid, value, dots, blank_lz, output in_ready);
endinterface

// File: rtl/seg4_scan_ctrl_bin2bcd_seq.sv
// Serial 16-bit binary to 20-bit BCD converter; one bit per clock, done on the 16th shift edge.
module bin2bcd_seq
  import seg4_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] sr;
  logic [3:0]  cnt;
  logic        busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr   <= bin;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      bcd <= dabble_step(bcd, sr[15]);
      sr  <= {sr[14:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) busy <= 1'b0;
    end
  end

  // Combinational so the caller can leave CONV on the same edge as the last shift
  always_comb begin
    done = busy && (cnt == 4'd15);
  end

endmodule

// File: rtl/seg4_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller: accepts a value, converts to BCD,
// and scans the digits with a dead-time gap at the start of every slot.
module seg4_scan_ctrl
  import seg4_scan_ctrl_pkg::*;
#(
  parameter int SLOT_CYCLES  = 16000,
  parameter int BLANK_CYCLES = 800
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  seg4_scan_ctrl_if.slave       bus,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  ovf
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  state_t state, state_next;
  logic   start, commit, conv_done;

  logic [19:0] bcd;
  logic [3:0]  dots_q;
  logic        blank_lz_q;

  // Patterns are active-high with dp in bit 7 until the output register
  logic [7:0] new_pat [NUM_DIGITS];
  logic       new_ovf;
  logic [7:0] shadow  [NUM_DIGITS];
  logic       shadow_ovf;
  logic [7:0] active  [NUM_DIGITS];

  logic [CW-1:0] slot_cnt;
  logic [1:0]    dig_idx;
  logic          frame_start;
  logic [7:0]    cur_pat;

  // ---------------- handshake / conversion FSM ----------------
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          start      = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV:   if (conv_done) state_next = ST_COMMIT;
      ST_COMMIT: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dots_q     <= '0;
      blank_lz_q <= 1'b0;
    end else if (start) begin
      dots_q     <= bus.dots;
      blank_lz_q <= bus.blank_lz;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (start),
    .bin   (bus.value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // ---------------- pattern generation and shadow registers ----------------
  always_comb begin : pat_build
    logic [3:0] digit;
    logic       lead;
    digit   = '0;
    new_ovf = (bcd[19:16] != 4'd0);
    lead    = blank_lz_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit = bcd[4*(NUM_DIGITS-1-i) +: 4];
      if (digit != 4'd0) lead = 1'b0;
      if (new_ovf)                            new_pat[i] = {1'b0, SEG_DASH};
      else if (lead && (i != NUM_DIGITS - 1)) new_pat[i] = {dots_q[i], SEG_BLANK};
      else                                    new_pat[i] = {dots_q[i], seg_of(digit)};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow     <= '{default: '0};
      shadow_ovf <= 1'b0;
    end else if (commit) begin
      shadow     <= new_pat;
      shadow_ovf <= new_ovf;
    end
  end

  // ---------------- scanning ----------------
  always_comb begin
    frame_start = (slot_cnt == '0) && (dig_idx == 2'd0);
    // On the copy edge the output must already use the value being copied
    cur_pat     = frame_start ? shadow[dig_idx] : active[dig_idx];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      active   <= '{default: '0};
      ovf      <= 1'b0;
      seg_n    <= '1;
      dig_en   <= '0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_start) begin
        active <= shadow;
        ovf    <= shadow_ovf;
      end
      if (slot_cnt < BLANK_END) begin
        seg_n  <= '1;
        dig_en <= '0;
      end else begin
        seg_n  <= ~cur_pat;
        dig_en <= 4'b0001 << dig_idx;
      end
    end
  end

endmodule

// File: tb/tb_seg4_scan_ctrl.sv
// Randomized self-checking bench for seg4_scan_ctrl against a cycle-count based display model.
module tb_seg4_scan_ctrl;

  localparam int S  = 20;
  localparam int B  = 4;
  localparam int FR = 4 * S;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] seg_n;
  logic [3:0] dig_en;
  logic       ovf;

  seg4_scan_ctrl_if bus();

  seg4_scan_ctrl #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .bus    (bus.slave),
    .seg_n  (seg_n),
    .dig_en (dig_en),
    .ovf    (ovf)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  bit done    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit         vld;
    int         v;
    logic [3:0] d;
    bit         bl;
  } rec_t;

  logic [6:0] pat7 [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [7:0] digit_pat(input rec_t r, input int i);
    int q;
    if (!r.vld) return 8'h00;
    if (r.v > 9999) return 8'h40;
    q = r.v / ((i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1);
    if (r.bl && q == 0 && i < 3) return {r.d[i], 7'h00};
    return {r.d[i], pat7[q % 10]};
  endfunction

  rec_t        shadow, active, pend_rec;
  bit          pend;
  int unsigned k, commit_at, pos, c, idx;
  bit          rdy;
  logic [7:0]  e_seg   = 8'hFF;
  logic [3:0]  e_dig   = 4'h0;
  logic        e_ovf   = 1'b0;
  logic        e_ready = 1'b1;

  always @(posedge CLK) begin
    if (!RST_N) begin
      k       = 0;
      pend    = 1'b0;
      shadow  = '{vld: 1'b0, v: 0, d: 4'h0, bl: 1'b0};
      active  = shadow;
      e_seg   = 8'hFF;
      e_dig   = 4'h0;
      e_ovf   = 1'b0;
      e_ready = 1'b1;
    end else begin
      pos = k;
      k++;
      c   = pos % S;
      idx = (pos / S) % 4;
      if (pos % FR == 0) active = shadow;
      if (c < B) begin
        e_seg = 8'hFF;
        e_dig = 4'h0;
      end else begin
        e_seg = ~digit_pat(active, int'(idx));
        e_dig = 4'b0001 << idx;
      end
      e_ovf = active.vld && (active.v > 9999);
      rdy = !pend;
      if (pend && k == commit_at) begin
        shadow = pend_rec;
        pend   = 1'b0;
      end
      if (rdy && bus.in_valid) begin
        pend_rec  = '{vld: 1'b1, v: int'(bus.value), d: bus.dots, bl: bus.blank_lz};
        pend      = 1'b1;
        commit_at = k + 17;
      end
      e_ready = !pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (!done) begin
        chk("seg_n", seg_n, e_seg);
        chk("dig_en", dig_en, e_dig);
        chk("ovf", ovf, e_ovf);
        chk("in_ready", bus.in_ready, e_ready);
        chk("dig_en_onehot", 32'($countones(dig_en) <= 1), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] v, input logic [3:0] d, input logic bl);
    int n;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.value    = v;
    bus.dots     = d;
    bus.blank_lz = bl;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) timeout_fail("send_ready");
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_dig(input int d, output logic [7:0] s);
    int n;
    n = 0;
    while (dig_en !== (4'b0001 << d) && n < 6 * S) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 6 * S) timeout_fail("wait_dig");
    s = seg_n;
  endtask

  task automatic settle();
    repeat (17 + FR + 2) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] s;
    int n;
    bus.in_valid = 1'b0;
    bus.value    = '0;
    bus.dots     = '0;
    bus.blank_lz = 1'b0;

    // Reset and blank first frame
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_seg_n", seg_n, 8'hFF);
    chk("rst_dig_en", dig_en, 4'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    wait_dig(0, s); chk("blank_frame_d0", s, 8'hFF);

    // 1234 with dp on digit 1
    send(16'd1234, 4'b0010, 1'b0);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("busy_cycles", n, 17);
    repeat (FR + 2) @(negedge CLK);
    wait_dig(0, s); chk("v1234_d0", s, 8'hF9);
    wait_dig(1, s); chk("v1234_d1", s, 8'h24);
    wait_dig(2, s); chk("v1234_d2", s, 8'hB0);
    wait_dig(3, s); chk("v1234_d3", s, 8'h99);
    chk("v1234_ovf", ovf, 1'b0);

    // Leading-zero blanking
    send(16'd7, 4'b0000, 1'b1);
    settle();
    wait_dig(0, s); chk("v7_d0", s, 8'hFF);
    wait_dig(3, s); chk("v7_d3", s, 8'hF8);
    send(16'd0, 4'b0000, 1'b1);
    settle();
    wait_dig(2, s); chk("v0_d2", s, 8'hFF);
    wait_dig(3, s); chk("v0_d3", s, 8'hC0);

    // Overflow
    send(16'd10000, 4'b0000, 1'b0);
    settle();
    wait_dig(0, s); chk("v10000_d0", s, 8'hBF);
    chk("v10000_ovf", ovf, 1'b1);
    send(16'd65535, 4'b1111, 1'b1);
    settle();
    wait_dig(2, s); chk("v65535_d2", s, 8'hBF);
    send(16'd9999, 4'b0000, 1'b0);
    settle();
    wait_dig(0, s); chk("v9999_d0", s, 8'h90);
    chk("v9999_ovf", ovf, 1'b0);

    // COMMIT lands exactly on the frame-start copy edge
    n = 0;
    while (k % FR != FR - 17 && n < 3 * FR) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3 * FR) timeout_fail("align_copy");
    bus.in_valid = 1'b1;
    bus.value    = 16'd1234;
    bus.dots     = 4'b0000;
    bus.blank_lz = 1'b0;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (17) @(negedge CLK);
    wait_dig(3, s); chk("copy_edge_old_d3", s, 8'h90);
    repeat (S) @(negedge CLK);
    wait_dig(3, s); chk("copy_edge_new_d3", s, 8'h99);

    // Reset in the middle of a conversion
    send(16'd4321, 4'b0000, 1'b0);
    repeat (7) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_seg_n", seg_n, 8'hFF);
    chk("midrst_dig_en", dig_en, 4'h0);
    settle();
    wait_dig(3, s); chk("midrst_d3_blank", s, 8'hFF);

    // in_valid held through the busy window must be accepted only once
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.value    = 16'd5555;
    bus.dots     = 4'b0000;
    bus.blank_lz = 1'b0;
    repeat (12) @(negedge CLK);
    bus.in_valid = 1'b0;
    settle();
    wait_dig(3, s); chk("hold_d3", s, 8'h92);

    // Randomized traffic, including mid-frame updates and back-to-back offers
    for (int it = 0; it < 40; it++) begin
      logic [15:0] v;
      case ($urandom_range(0, 4))
        0:       v = 16'($urandom_range(0, 9));
        1:       v = 16'($urandom_range(0, 99));
        2:       v = 16'($urandom_range(0, 9999));
        3:       v = 16'($urandom_range(10000, 65535));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      send(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 40)) @(negedge CLK);
    end
    repeat (2 * FR) @(negedge CLK);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
